ddr_arbiter: RTL and testbench
==============================

// Module: ddr_arbiter
// PURPOSE
//  Shares the single DDRAM Avalon-MM master port between N_PORTS burst requesters,
//  e.g. port 0 = ROM download writer, port 1 = frame buffer/sprite fetch.
//  Round-robin grant per burst. Holds the grant until the whole burst completes.
//  Sits inside Main, in the clock (clk_sys) domain, directly in front of the DDRAM port pins.
// PARAMETERS
//  N_PORTS  2   number of requesters (>=2)
//  ADDR_W   32  byte address width (top level uses [31:3] as the DDRAM word address)
//  DATA_W   64  data width
//  BURST_W  8   burst count width
// PORTS
//  clock           in   1              clk_sys
//  reset           in   1              async, active-high
//  in_rd           in   N_PORTS        per-port read request
//  in_wr           in   N_PORTS        per-port write request
//  in_addr         in   N_PORTS*ADDR_W per-port byte address
//  in_burst_count  in   N_PORTS*BURST_W per-port burst length in words
//  in_mask         in   N_PORTS*DATA_W/8 per-port byte enables
//  in_din          in   N_PORTS*DATA_W per-port write data
//  in_wait_req     out  N_PORTS        per-port stall
//  in_valid        out  N_PORTS        read data valid, granted port only
//  in_dout         out  DATA_W         ddr_dout broadcast to all ports
//  in_burst_done   out  N_PORTS        1-cycle pulse on the last word of a burst
//  ddr_rd          out  1              read command to DDRAM
//  ddr_wr          out  1              write command to DDRAM
//  ddr_addr        out  ADDR_W         DDRAM byte address
//  ddr_burst_count out  BURST_W        DDRAM burst length
//  ddr_mask        out  DATA_W/8       DDRAM byte enables
//  ddr_din         out  DATA_W         DDRAM write data
//  ddr_dout        in   DATA_W         DDRAM read data
//  ddr_wait_req    in   1              DDRAM busy
//  ddr_valid       in   1              DDRAM read data ready
// BEHAVIOUR
//  Reset values (asynchronous, forced while reset is high):
//   - state=IDLE, last=N_PORTS-1, word count=0.
//   - ddr_rd=0, ddr_wr=0, in_wait_req all 1, in_valid=0, in_burst_done=0.
//  States: IDLE, READ, WRITE.
//  IDLE:
//   - Arbitration is combinational. Candidate sel = first port with rd|wr, searching from last+1 and wrapping.
//   - The sel command goes to ddr_* in the same cycle (0-cycle latency).
//   - in_wait_req[sel]=ddr_wait_req. Every other port sees in_wait_req=1.
//   - On acceptance (!ddr_wait_req), latch gnt=sel, last=sel, burst=in_burst_count[sel].
//   - A burst count of 0 is treated as 1.
//   - Accepted rd goes to READ with count=0.
//   - Accepted wr with burst==1: pulse in_burst_done[sel] and stay in IDLE.
//   - Accepted wr with burst>1: go to WRITE with count=1.
//   - No request: ddr_rd=ddr_wr=0. ddr_addr, ddr_din and ddr_mask hold the port-0 values (don't care).
//  READ:
//   - ddr_rd=ddr_wr=0. All in_wait_req=1.
//   - in_valid[gnt]=ddr_valid. Each valid beat increments count.
//   - On the valid beat with count==burst-1: pulse in_burst_done[gnt] and go to IDLE.
//   - The next arbitration happens in the following cycle.
//  WRITE:
//   - ddr_wr=in_wr[gnt]. ddr_din and ddr_mask come from gnt. ddr_rd=0.
//   - in_wait_req[gnt]=ddr_wait_req. Other ports see 1.
//   - Count accepted beats (in_wr[gnt] & !ddr_wait_req).
//   - The last beat pulses in_burst_done[gnt] and goes to IDLE.
//  Rules:
//   - A requester holds its command stable while its in_wait_req=1 (Avalon).
//   - Any in_* change after acceptance, other than write beats, is ignored.
//   - rd and wr asserted together on one port: read wins, wr is ignored. Simulation assertion fires.
//   - A requester that drops its request before acceptance loses its turn. No state change.
//   - Stray ddr_valid outside READ is ignored, and in_valid stays 0.
//   - Counter is BURST_W+1 bits, so a 2^BURST_W-1 word burst cannot wrap.
//   - Reset mid-burst aborts it. No in_burst_done pulse. DDR-side recovery is the system reset's job.
// STRUCTURE
//  Package cave_ddr_pkg:
//   - typedef enum {IDLE, READ, WRITE} ddr_arb_state_t
//   - localparams DDR_ADDR_W, DDR_DATA_W, DDR_BURST_W, shared with the download and frame buffer masters.
//  Sub-module rr_arbiter #(N):
//   - inputs req[N] and last index; output onehot/index sel.
//   - Purely combinational. Instantiated once.
// TESTING
//  1. Single read: port1 rd, addr=0x100, burst=4, wait_req low.
//     -> ddr_rd the same cycle; four ddr_valid beats reach in_valid[1] only; in_burst_done[1] on beat 4.
//  2. Contention: port0 and port1 both wr, burst=2, starting from reset.
//     -> port0 granted first (last=1); port1 follows immediately; then port0 again if it re-requests.
//  3. Backpressure: port0 write burst=3, ddr_wait_req high 2 cycles on beat 2.
//     -> in_wait_req[0] tracks it; exactly 3 words written, in order; port1 stalls the whole time.
//  4. Burst edge cases: port0 wr with burst=0, then with burst=1.
//     -> each gives 1 word and an in_burst_done pulse; the arbiter never leaves IDLE.
//  5. Reset mid-burst: port1 read burst=8, reset after 3 valid beats.
//     -> outputs go to reset values immediately; no done pulse; next port0 request is granted first.
//  6. Illegal input: port0 rd&wr together -> read performed, assertion fires; stray ddr_valid in IDLE -> in_valid stays 0.

Source files
------------

// File: rtl/cave_ddr_pkg.sv
// ---------------------------------------------------------------------------
// cave_ddr_pkg
// Shared definitions for everything that talks to the DDRAM Avalon-MM port:
// the arbiter FSM state type and the default bus widths. The download and
// frame buffer masters use the same widths.
// ---------------------------------------------------------------------------
package cave_ddr_pkg;

  localparam int DDR_ADDR_W  = 32;
  localparam int DDR_DATA_W  = 64;
  localparam int DDR_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } ddr_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. It searches the request vector
// starting at last+1, wraps around, and returns the first requester found.
// Ports:
//   req        in   N      request per port
//   last       in   IDX_W  index of the most recently granted port
//   sel_onehot out  N      one-hot selection (all zero when nobody requests)
//   sel_idx    out  IDX_W  index of the selection (0 when nobody requests)
//   sel_valid  out  1      at least one port is requesting
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     sel_onehot,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid
);

  int p;

  // Walk ports last+1 .. last+N (mod N); the first hit wins.
  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    sel_valid  = 1'b0;
    p          = 0;
    for (int i = 1; i <= N; i++) begin
      p = (int'(last) + i) % N;
      if (!sel_valid && req[p]) begin
        sel_valid     = 1'b1;
        sel_idx       = IDX_W'(p);
        sel_onehot[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_arbiter
// Shares the single DDRAM Avalon-MM master port between N_PORTS burst
// requesters (e.g. ROM download writer and frame buffer fetch). Grants are
// round-robin per burst and the grant is held until the burst completes.
// The command of the selected port reaches the DDRAM pins in the same cycle.
// Ports:
//   clock, reset                 clk_sys, async active-high reset
//   in_rd/in_wr                  per-port read/write request
//   in_addr/in_burst_count       per-port byte address and burst length
//   in_mask/in_din               per-port byte enables and write data
//   in_wait_req                  per-port stall
//   in_valid                     read data valid (granted port only)
//   in_dout                      DDRAM read data broadcast to all ports
//   in_burst_done                one-cycle pulse on the last word of a burst
//   ddr_*                        DDRAM Avalon-MM master side
// ---------------------------------------------------------------------------
module ddr_arbiter
  import cave_ddr_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = DDR_ADDR_W,
  parameter int DATA_W  = DDR_DATA_W,
  parameter int BURST_W = DDR_BURST_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_PORTS-1:0]            in_rd,
  input  logic [N_PORTS-1:0]            in_wr,
  input  logic [N_PORTS*ADDR_W-1:0]     in_addr,
  input  logic [N_PORTS*BURST_W-1:0]    in_burst_count,
  input  logic [N_PORTS*DATA_W/8-1:0]   in_mask,
  input  logic [N_PORTS*DATA_W-1:0]     in_din,
  output logic [N_PORTS-1:0]            in_wait_req,
  output logic [N_PORTS-1:0]            in_valid,
  output logic [DATA_W-1:0]             in_dout,
  output logic [N_PORTS-1:0]            in_burst_done,
  output logic                          ddr_rd,
  output logic                          ddr_wr,
  output logic [ADDR_W-1:0]             ddr_addr,
  output logic [BURST_W-1:0]            ddr_burst_count,
  output logic [DATA_W/8-1:0]           ddr_mask,
  output logic [DATA_W-1:0]             ddr_din,
  input  logic [DATA_W-1:0]             ddr_dout,
  input  logic                          ddr_wait_req,
  input  logic                          ddr_valid
);

  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int MASK_W = DATA_W / 8;

  ddr_arb_state_t       state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [BURST_W:0]     burst_q, burst_d;
  logic [BURST_W:0]     count_q, count_d;

  logic [N_PORTS-1:0]   sel_onehot;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic [IDX_W-1:0]     mux_idx;
  logic [BURST_W-1:0]   sel_bc;
  logic [BURST_W:0]     sel_burst;
  logic                 count_last;

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (in_rd | in_wr),
    .last       (last_q),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .sel_valid  (sel_valid)
  );

  // While idle the bus follows the arbitration winner; during a write burst
  // it follows the granted port.
  assign mux_idx   = (state_q == IDLE) ? sel_idx : gnt_q;
  assign sel_bc    = in_burst_count[int'(sel_idx)*BURST_W +: BURST_W];
  // A burst count of 0 is handled as a single-word burst.
  assign sel_burst = (sel_bc == '0) ? (BURST_W+1)'(1) : {1'b0, sel_bc};
  assign count_last = (count_q == (burst_q - 1'b1));

  assign ddr_addr = in_addr[int'(mux_idx)*ADDR_W +: ADDR_W];
  assign ddr_mask = in_mask[int'(mux_idx)*MASK_W +: MASK_W];
  assign ddr_din  = in_din[int'(mux_idx)*DATA_W +: DATA_W];
  assign in_dout  = ddr_dout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_PORTS - 1);
      gnt_q   <= '0;
      burst_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      count_q <= count_d;
    end
  end

  // Next state and handshake outputs. Reset forces the handshake outputs to
  // their idle values straight away, even between clock edges.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    gnt_d           = gnt_q;
    burst_d         = burst_q;
    count_d         = count_q;
    ddr_rd          = 1'b0;
    ddr_wr          = 1'b0;
    ddr_burst_count = burst_q[BURST_W-1:0];
    in_wait_req     = '1;
    in_valid        = '0;
    in_burst_done   = '0;

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          ddr_burst_count = sel_burst[BURST_W-1:0];
          if (sel_valid) begin
            // Read wins when a port raises rd and wr together.
            ddr_rd      = in_rd[sel_idx];
            ddr_wr      = in_wr[sel_idx] & ~in_rd[sel_idx];
            in_wait_req = ~sel_onehot | {N_PORTS{ddr_wait_req}};
            if (!ddr_wait_req) begin
              gnt_d   = sel_idx;
              last_d  = sel_idx;
              burst_d = sel_burst;
              if (in_rd[sel_idx]) begin
                state_d = READ;
                count_d = '0;
              end else if (sel_burst == (BURST_W+1)'(1)) begin
                in_burst_done = sel_onehot;
              end else begin
                state_d = WRITE;
                count_d = (BURST_W+1)'(1);
              end
            end
          end
        end

        READ: begin
          in_valid[gnt_q] = ddr_valid;
          if (ddr_valid) begin
            count_d = count_q + 1'b1;
            if (count_last) begin
              in_burst_done[gnt_q] = 1'b1;
              state_d              = IDLE;
            end
          end
        end

        WRITE: begin
          ddr_wr             = in_wr[gnt_q];
          in_wait_req[gnt_q] = ddr_wait_req;
          if (in_wr[gnt_q] && !ddr_wait_req) begin
            count_d = count_q + 1'b1;
            if (count_last) begin
              in_burst_done[gnt_q] = 1'b1;
              state_d              = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Flags a requester that raises rd and wr together; the read is performed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(|(in_rd & in_wr)))
        else $warning("ddr_arbiter: rd and wr raised together on one port, read takes priority");
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_arbiter
// Directed bench for ddr_arbiter with two ports and default widths.
// ---------------------------------------------------------------------------
module tb_ddr_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   in_rd, in_wr;
  logic [63:0]  in_addr;
  logic [15:0]  in_burst_count;
  logic [15:0]  in_mask;
  logic [127:0] in_din;
  logic [1:0]   in_wait_req, in_valid, in_burst_done;
  logic [63:0]  in_dout;
  logic         ddr_rd, ddr_wr;
  logic [31:0]  ddr_addr;
  logic [7:0]   ddr_burst_count, ddr_mask;
  logic [63:0]  ddr_din, ddr_dout;
  logic         ddr_wait_req, ddr_valid;

  int checks = 0;
  int errors = 0;

  ddr_arbiter #(
    .N_PORTS (2),
    .ADDR_W  (32),
    .DATA_W  (64),
    .BURST_W (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_rd           (in_rd),
    .in_wr           (in_wr),
    .in_addr         (in_addr),
    .in_burst_count  (in_burst_count),
    .in_mask         (in_mask),
    .in_din          (in_din),
    .in_wait_req     (in_wait_req),
    .in_valid        (in_valid),
    .in_dout         (in_dout),
    .in_burst_done   (in_burst_done),
    .ddr_rd          (ddr_rd),
    .ddr_wr          (ddr_wr),
    .ddr_addr        (ddr_addr),
    .ddr_burst_count (ddr_burst_count),
    .ddr_mask        (ddr_mask),
    .ddr_din         (ddr_din),
    .ddr_dout        (ddr_dout),
    .ddr_wait_req    (ddr_wait_req),
    .ddr_valid       (ddr_valid)
  );

  always #5 clock = ~clock;

  // Drives one port's full command.
  task automatic applyStimulus(input int p, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [7:0] bc,
                               input logic [7:0] mask, input logic [63:0] din);
    in_rd[p]                 = rd;
    in_wr[p]                 = wr;
    in_addr[p*32 +: 32]      = addr;
    in_burst_count[p*8 +: 8] = bc;
    in_mask[p*8 +: 8]        = mask;
    in_din[p*64 +: 64]       = din;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
  task automatic nextCycle;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    reset          = 1'b1;
    in_rd          = '0;
    in_wr          = '0;
    in_addr        = '0;
    in_burst_count = '0;
    in_mask        = '0;
    in_din         = '0;
    ddr_dout       = '0;
    ddr_wait_req   = 1'b0;
    ddr_valid      = 1'b0;

    // Reset values, with a pending request that must not leak through
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h100, 8'd4, 8'hFF, 64'h0);
    ddr_valid = 1'b1;
    settle();
    checkOutput("rst_ddr_rd", ddr_rd, 1'b0);
    checkOutput("rst_ddr_wr", ddr_wr, 1'b0);
    checkOutput("rst_wait_req", in_wait_req, 2'b11);
    checkOutput("rst_valid", in_valid, 2'b00);
    checkOutput("rst_done", in_burst_done, 2'b00);
    nextCycle();
    ddr_valid = 1'b0;
    reset     = 1'b0;

    // 1. Single read, port 1, burst 4
    settle();
    checkOutput("t1_ddr_rd", ddr_rd, 1'b1);
    checkOutput("t1_ddr_addr", ddr_addr, 32'h100);
    checkOutput("t1_ddr_bc", ddr_burst_count, 8'd4);
    checkOutput("t1_wait_req", in_wait_req, 2'b01);
    nextCycle();
    in_rd[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ddr_valid = 1'b1;
      ddr_dout  = 64'hD000 + 64'(b);
      settle();
      checkOutput("t1_valid", in_valid, 2'b10);
      checkOutput("t1_dout", in_dout, 64'hD000 + 64'(b));
      checkOutput("t1_done", in_burst_done, (b == 3) ? 2'b10 : 2'b00);
      checkOutput("t1_ddr_rd_busy", ddr_rd, 1'b0);
      nextCycle();
      ddr_valid = 1'b0;
      settle();
      checkOutput("t1_gap_valid", in_valid, 2'b00);
      nextCycle();
    end
    checkOutput("t1_idle_wait_req", in_wait_req, 2'b11);

    // 2. Contention from reset: both ports write burst 2
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b1, 32'h1000, 8'd2, 8'h0F, 64'hA0);
    applyStimulus(1, 1'b0, 1'b1, 32'h2000, 8'd2, 8'hF0, 64'hB0);
    settle();
    checkOutput("t2_p0_wait", in_wait_req, 2'b10);
    checkOutput("t2_p0_wr", ddr_wr, 1'b1);
    checkOutput("t2_p0_din0", ddr_din, 64'hA0);
    checkOutput("t2_p0_mask", ddr_mask, 8'h0F);
    checkOutput("t2_p0_addr", ddr_addr, 32'h1000);
    nextCycle();
    in_din[63:0] = 64'hA1;
    settle();
    checkOutput("t2_p0_din1", ddr_din, 64'hA1);
    checkOutput("t2_p0_done", in_burst_done, 2'b01);
    checkOutput("t2_p0_wait1", in_wait_req, 2'b10);
    nextCycle();
    in_wr[0] = 1'b0;
    settle();
    checkOutput("t2_p1_wait", in_wait_req, 2'b01);
    checkOutput("t2_p1_din0", ddr_din, 64'hB0);
    checkOutput("t2_p1_mask", ddr_mask, 8'hF0);
    nextCycle();
    in_din[127:64] = 64'hB1;
    applyStimulus(0, 1'b0, 1'b1, 32'h1100, 8'd2, 8'h0F, 64'hA2);
    settle();
    checkOutput("t2_p1_din1", ddr_din, 64'hB1);
    checkOutput("t2_p1_done", in_burst_done, 2'b10);
    checkOutput("t2_p1_wait1", in_wait_req, 2'b01);
    nextCycle();
    in_din[127:64] = 64'hB2;
    settle();
    checkOutput("t2_p0_again_din", ddr_din, 64'hA2);
    checkOutput("t2_p0_again_wait", in_wait_req, 2'b10);
    nextCycle();
    in_din[63:0] = 64'hA3;
    settle();
    checkOutput("t2_p0_again_done", in_burst_done, 2'b01);
    nextCycle();
    in_wr = 2'b00;
    settle();
    checkOutput("t2_idle_wr", ddr_wr, 1'b0);
    nextCycle();

    // 3. Backpressure on beat 2 of a 3-word write from port 0
    applyStimulus(0, 1'b0, 1'b1, 32'h3000, 8'd3, 8'hFF, 64'hC0);
    settle();
    checkOutput("t3_beat1_din", ddr_din, 64'hC0);
    checkOutput("t3_beat1_wait", in_wait_req, 2'b10);
    nextCycle();
    in_din[63:0] = 64'hC1;
    applyStimulus(1, 1'b0, 1'b1, 32'h4000, 8'd1, 8'hFF, 64'hE0);
    ddr_wait_req = 1'b1;
    for (int s = 0; s < 2; s++) begin
      settle();
      checkOutput("t3_stall_wait", in_wait_req, 2'b11);
      checkOutput("t3_stall_din", ddr_din, 64'hC1);
      checkOutput("t3_stall_wr", ddr_wr, 1'b1);
      checkOutput("t3_stall_done", in_burst_done, 2'b00);
      nextCycle();
    end
    ddr_wait_req = 1'b0;
    settle();
    checkOutput("t3_beat2_wait", in_wait_req, 2'b10);
    checkOutput("t3_beat2_din", ddr_din, 64'hC1);
    checkOutput("t3_beat2_done", in_burst_done, 2'b00);
    nextCycle();
    in_din[63:0] = 64'hC2;
    settle();
    checkOutput("t3_beat3_din", ddr_din, 64'hC2);
    checkOutput("t3_beat3_done", in_burst_done, 2'b01);
    checkOutput("t3_beat3_wait", in_wait_req, 2'b10);
    nextCycle();
    in_wr[0] = 1'b0;
    settle();
    checkOutput("t3_p1_din", ddr_din, 64'hE0);
    checkOutput("t3_p1_wait", in_wait_req, 2'b01);
    checkOutput("t3_p1_done", in_burst_done, 2'b10);
    nextCycle();
    in_wr = 2'b00;

    // 4. Burst count 0 then 1 on port 0: single words, always back in IDLE
    applyStimulus(0, 1'b0, 1'b1, 32'h5000, 8'd0, 8'h3C, 64'hF0);
    settle();
    checkOutput("t4_bc0_count", ddr_burst_count, 8'd1);
    checkOutput("t4_bc0_wr", ddr_wr, 1'b1);
    checkOutput("t4_bc0_done", in_burst_done, 2'b01);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b1, 32'h5008, 8'd1, 8'h3C, 64'hF1);
    settle();
    checkOutput("t4_bc1_din", ddr_din, 64'hF1);
    checkOutput("t4_bc1_done", in_burst_done, 2'b01);
    checkOutput("t4_bc1_wait", in_wait_req, 2'b10);
    nextCycle();
    in_wr = 2'b00;
    settle();
    checkOutput("t4_idle_wr", ddr_wr, 1'b0);
    checkOutput("t4_idle_done", in_burst_done, 2'b00);
    nextCycle();

    // 5. Reset in the middle of an 8-word read on port 1
    applyStimulus(1, 1'b1, 1'b0, 32'h200, 8'd8, 8'hFF, 64'h0);
    settle();
    checkOutput("t5_ddr_rd", ddr_rd, 1'b1);
    nextCycle();
    in_rd[1] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      ddr_valid = 1'b1;
      settle();
      checkOutput("t5_valid", in_valid, 2'b10);
      checkOutput("t5_done", in_burst_done, 2'b00);
      nextCycle();
    end
    reset = 1'b1;
    settle();
    checkOutput("t5_rst_valid", in_valid, 2'b00);
    checkOutput("t5_rst_done", in_burst_done, 2'b00);
    checkOutput("t5_rst_wait", in_wait_req, 2'b11);
    ddr_valid = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 8'd1, 8'hFF, 64'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h200, 8'd8, 8'hFF, 64'h0);
    settle();
    checkOutput("t5_rst_ddr_rd", ddr_rd, 1'b0);
    nextCycle();
    reset = 1'b0;
    settle();
    checkOutput("t5_after_wait", in_wait_req, 2'b10);
    checkOutput("t5_after_addr", ddr_addr, 32'h400);
    checkOutput("t5_after_rd", ddr_rd, 1'b1);
    nextCycle();
    in_rd     = 2'b00;
    ddr_valid = 1'b1;
    settle();
    checkOutput("t5_p0_valid", in_valid, 2'b01);
    checkOutput("t5_p0_done", in_burst_done, 2'b01);
    nextCycle();
    ddr_valid = 1'b0;

    // 6. rd and wr together on port 0, then stray ddr_valid while idle
    applyStimulus(0, 1'b1, 1'b1, 32'h300, 8'd1, 8'hFF, 64'h55);
    settle();
    checkOutput("t6_both_rd", ddr_rd, 1'b1);
    checkOutput("t6_both_wr", ddr_wr, 1'b0);
    checkOutput("t6_both_done", in_burst_done, 2'b00);
    nextCycle();
    in_rd     = 2'b00;
    in_wr     = 2'b00;
    ddr_valid = 1'b1;
    settle();
    checkOutput("t6_read_valid", in_valid, 2'b01);
    checkOutput("t6_read_done", in_burst_done, 2'b01);
    nextCycle();
    settle();
    checkOutput("t6_stray_valid", in_valid, 2'b00);
    checkOutput("t6_stray_done", in_burst_done, 2'b00);
    checkOutput("t6_stray_rd", ddr_rd, 1'b0);
    nextCycle();
    ddr_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
